wm_phase_timer: RTL and testbench
=================================

Name: wm_phase_timer

Overview:
- Phase timer for the washing-machine controller.
- It watches the controller's 3-bit state code and counts clock edges spent continuously in the current state.
- It raises completion flags when the programmed duration for that phase has elapsed: fill finished (sig_Full), heating finished (sig_Temperature), wash/rinse/spin finished (sig_Completed).
- The controller FSM consumes these flags to advance its state.

Parameters:
- CNT_W, 16, width of the elapsed-edge counter.
- FILL_CYCLES, 4, edges in FILL before sig_Full asserts (must be >= 1).
- HEAT_CYCLES, 3, edges in HEAT before sig_Temperature asserts (must be >= 1).
- WASH_CYCLES, 8, edges in WASH before sig_Completed asserts (must be >= 1).
- RINSE_CYCLES, 6, edges in RINSE before sig_Completed asserts (must be >= 1).
- SPIN_CYCLES, 5, edges in SPIN before sig_Completed asserts (must be >= 1).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- state  input  3  current controller state code.
- sig_Full  output  1  fill phase duration elapsed.
- sig_Temperature  output  1  heat phase duration elapsed.
- sig_Completed  output  1  wash/rinse/spin phase duration elapsed.

Behaviour:
- One clock; reset is asynchronous and active-high.
- State encoding: 0 IDLE, 1 FILL, 2 HEAT, 3 WASH, 4 RINSE, 5 SPIN; 6 and 7 are reserved and treated as IDLE.
- Registers: state_q (3 bits) and elapsed (CNT_W bits).
- Reset value: state_q = IDLE, elapsed = 0, so all three outputs are 0. Reset may assert at any time, including mid-phase; the outputs clear immediately without waiting for a clock edge.
- Each rising edge, with reset low:
  - state_q <= state.
  - If state differs from state_q, elapsed <= 1 (this edge is the first edge in the new state).
  - Otherwise, elapsed <= elapsed + 1, saturating at all-ones (no wrap-around).
- For IDLE and reserved codes, elapsed is forced to 0 at every edge.
- Outputs are decoded only from the registers (state_q, elapsed), never combinationally from the state input:
  - sig_Full = (state_q == FILL) and (elapsed >= FILL_CYCLES).
  - sig_Temperature = (state_q == HEAT) and (elapsed >= HEAT_CYCLES).
  - sig_Completed = state_q in {WASH, RINSE, SPIN} and elapsed >= that phase's duration.
- Latency: a flag is first high immediately after the Nth consecutive rising edge at which state equals the phase code (N = duration).
- Flags are levels. They stay high while the state is held, and drop at the first edge after the state changes (at that edge state_q updates and elapsed restarts at 1).
- At most one flag is high at a time.
- Returning to a phase (for example FILL -> HEAT -> FILL) restarts its count from 1. There is no memory of previous visits.
- A change of the state input between edges has no effect until the next edge.
- Saturation: once elapsed reaches all-ones it holds, and the flag stays asserted.

Decomposition:
- Shared package wm_pkg:
  - 3-bit state codes IDLE/FILL/HEAT/WASH/RINSE/SPIN as localparams or an enum typedef.
  - Default phase durations.
- The controller FSM and this timer both import wm_pkg.
- One natural sub-module: wm_sat_counter (CNT_W-bit saturating counter with synchronous load-1 / clear / increment, asynchronous reset). The top level holds state_q, the change detect and the output decode.

Test Plan:
- Reset: assert reset with state = FILL held for 10 edges -> all outputs 0, elapsed 0. Release reset -> sig_Full high after the 4th edge.
- HEAT timing: state = 0 for one edge, then state = 2 for three edges -> sig_Temperature 0 after edges 1–2 of HEAT and 1 after edge 3. sig_Full and sig_Completed stay 0 throughout.
- Early phase change: FILL for 3 edges, then HEAT -> sig_Full never asserts. HEAT count starts at 1 on the change edge, and sig_Temperature rises after the 3rd HEAT edge.
- Drop on exit and re-entry: WASH for 8 edges -> sig_Completed = 1. Change to RINSE -> sig_Completed = 0 after the next edge, then 1 after the 6th RINSE edge. Return to WASH -> 8 more edges are needed.
- Mid-phase reset: SPIN for 4 edges, pulse reset asynchronously between edges -> outputs 0 immediately. With SPIN held, sig_Completed rises 5 edges after reset release.
- Reserved and saturation: state = 7 for 20 edges -> all outputs 0. With CNT_W = 3 and state FILL for 20 edges -> elapsed holds at 7 and sig_Full stays 1.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: controller state codes and default phase durations.
// Used by both the controller FSM and the phase timer.
package wm_pkg;

  // code | meaning
  // 0    | IDLE
  // 1    | FILL   (ends on sig_Full)
  // 2    | HEAT   (ends on sig_Temperature)
  // 3    | WASH   (ends on sig_Completed)
  // 4    | RINSE  (ends on sig_Completed)
  // 5    | SPIN   (ends on sig_Completed)
  // 6,7  | reserved, behave as IDLE
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_HEAT  = 3'd2,
    ST_WASH  = 3'd3,
    ST_RINSE = 3'd4,
    ST_SPIN  = 3'd5,
    ST_RSV6  = 3'd6,
    ST_RSV7  = 3'd7
  } wm_state_e;

  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_FILL_CYCLES  = 4;
  localparam int unsigned DEF_HEAT_CYCLES  = 3;
  localparam int unsigned DEF_WASH_CYCLES  = 8;
  localparam int unsigned DEF_RINSE_CYCLES = 6;
  localparam int unsigned DEF_SPIN_CYCLES  = 5;

  // Only FILL..SPIN accumulate time; IDLE and reserved codes keep the timer cleared.
  function automatic logic is_timed_phase(input logic [2:0] code);
    return (code >= 3'(ST_FILL)) && (code <= 3'(ST_SPIN));
  endfunction

endpackage

// File: rtl/wm_sat_counter.sv
// Saturating up-counter with synchronous clear / load-one / increment and async reset.
// Clear wins over load-one, which wins over increment; the count holds at all-ones.
module wm_sat_counter
  import wm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_one,
  input  logic             incr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load_one) begin
      count <= CNT_W'(1);
    end else if (incr && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wm_phase_timer.sv
// Phase timer: counts edges spent continuously in the current controller state and
// raises the matching completion flag once that phase's programmed duration elapses.
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int          CNT_W        = DEF_CNT_W,
  parameter int unsigned FILL_CYCLES  = DEF_FILL_CYCLES,
  parameter int unsigned HEAT_CYCLES  = DEF_HEAT_CYCLES,
  parameter int unsigned WASH_CYCLES  = DEF_WASH_CYCLES,
  parameter int unsigned RINSE_CYCLES = DEF_RINSE_CYCLES,
  parameter int unsigned SPIN_CYCLES  = DEF_SPIN_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] state,
  output logic       sig_Full,
  output logic       sig_Temperature,
  output logic       sig_Completed
);

  wm_state_e        state_q;
  logic [CNT_W-1:0] elapsed;
  logic             changed;
  logic             timed;
  logic [31:0]      elapsed_w;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= wm_state_e'(state);
    end
  end

  assign changed = (state != 3'(state_q));
  assign timed   = is_timed_phase(state);

  // The edge that enters a phase is its first counted edge, hence load-one rather than clear.
  wm_sat_counter #(
    .CNT_W (CNT_W)
  ) u_elapsed (
    .clock    (clock),
    .reset    (reset),
    .clear    (!timed),
    .load_one (timed && changed),
    .incr     (timed && !changed),
    .count    (elapsed)
  );

  assign elapsed_w = 32'(elapsed);

  // Flags come from registered state only, so a mid-cycle input change cannot glitch them.
  always_comb begin
    sig_Full        = 1'b0;
    sig_Temperature = 1'b0;
    sig_Completed   = 1'b0;
    case (state_q)
      ST_FILL:  sig_Full        = (elapsed_w >= FILL_CYCLES);
      ST_HEAT:  sig_Temperature = (elapsed_w >= HEAT_CYCLES);
      ST_WASH:  sig_Completed   = (elapsed_w >= WASH_CYCLES);
      ST_RINSE: sig_Completed   = (elapsed_w >= RINSE_CYCLES);
      ST_SPIN:  sig_Completed   = (elapsed_w >= SPIN_CYCLES);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed bench for wm_phase_timer: default-width instance for phase timing plus a
// 3-bit-counter instance for saturation.
module tb_wm_phase_timer;

  logic       clock;
  logic       reset;
  logic [2:0] state;
  logic [2:0] state_s;
  logic       sig_Full, sig_Temperature, sig_Completed;
  logic       s_full, s_temp, s_comp;

  int checks = 0;
  int errors = 0;

  wm_phase_timer u_dut (
    .clock           (clock),
    .reset           (reset),
    .state           (state),
    .sig_Full        (sig_Full),
    .sig_Temperature (sig_Temperature),
    .sig_Completed   (sig_Completed)
  );

  wm_phase_timer #(.CNT_W(3)) u_sat (
    .clock           (clock),
    .reset           (reset),
    .state           (state_s),
    .sig_Full        (s_full),
    .sig_Temperature (s_temp),
    .sig_Completed   (s_comp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Expected flags packed as {sig_Full, sig_Temperature, sig_Completed}.
  task automatic chk_out(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {sig_Full, sig_Temperature, sig_Completed};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    state   = 3'd1;
    state_s = 3'd0;

    // Reset held with FILL on the input.
    step(10);
    chk_out("reset_hold_outs", 3'b000);
    chk_val("reset_hold_elapsed", 16'(u_dut.elapsed), 16'd0);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      chk_out($sformatf("fill_after_reset_e%0d", k), 3'b000);
    end
    step(1);
    chk_out("fill_after_reset_e4", 3'b100);

    // HEAT timing after one IDLE edge.
    state = 3'd0;
    step(1);
    chk_out("idle_edge", 3'b000);
    chk_val("idle_elapsed", 16'(u_dut.elapsed), 16'd0);
    state = 3'd2;
    step(1);
    chk_out("heat_e1", 3'b000);
    step(1);
    chk_out("heat_e2", 3'b000);
    step(1);
    chk_out("heat_e3", 3'b010);

    // Early exit from FILL: full never rises, HEAT restarts at 1.
    state = 3'd1;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      chk_out($sformatf("fill_short_e%0d", k), 3'b000);
    end
    state = 3'd2;
    step(1);
    chk_out("heat2_e1", 3'b000);
    chk_val("heat2_e1_elapsed", 16'(u_dut.elapsed), 16'd1);
    step(1);
    chk_out("heat2_e2", 3'b000);
    step(1);
    chk_out("heat2_e3", 3'b010);

    // WASH -> RINSE -> WASH.
    state = 3'd3;
    step(7);
    chk_out("wash_e7", 3'b000);
    step(1);
    chk_out("wash_e8", 3'b001);
    // Input glitch between edges must not reach the flags.
    state = 3'd1;
    #2;
    chk_out("wash_glitch", 3'b001);
    state = 3'd3;
    step(1);
    chk_out("wash_e9_held", 3'b001);
    state = 3'd4;
    step(1);
    chk_out("rinse_e1", 3'b000);
    step(4);
    chk_out("rinse_e5", 3'b000);
    step(1);
    chk_out("rinse_e6", 3'b001);
    state = 3'd3;
    step(7);
    chk_out("rewash_e7", 3'b000);
    step(1);
    chk_out("rewash_e8", 3'b001);

    // Mid-phase asynchronous reset in SPIN.
    state = 3'd5;
    step(4);
    chk_out("spin_e4", 3'b000);
    chk_val("spin_e4_elapsed", 16'(u_dut.elapsed), 16'd4);
    #2;
    reset = 1'b1;
    #1;
    chk_out("spin_async_reset", 3'b000);
    chk_val("spin_async_reset_elapsed", 16'(u_dut.elapsed), 16'd0);
    reset = 1'b0;
    step(4);
    chk_out("spin_post_reset_e4", 3'b000);
    step(1);
    chk_out("spin_post_reset_e5", 3'b001);
    // Reset while a flag is high clears it without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk_out("spin_flag_async_reset", 3'b000);
    reset = 1'b0;

    // Reserved codes behave as IDLE.
    state = 3'd7;
    step(20);
    chk_out("rsv7_e20", 3'b000);
    chk_val("rsv7_elapsed", 16'(u_dut.elapsed), 16'd0);
    state = 3'd6;
    step(3);
    chk_out("rsv6_e3", 3'b000);

    // Saturation with a 3-bit counter.
    state_s = 3'd1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk_val($sformatf("sat_elapsed_e%0d", k), 16'(u_sat.elapsed), 16'((k < 7) ? k : 7));
      chk_val($sformatf("sat_full_e%0d", k), 16'(s_full), 16'((k >= 4) ? 1 : 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
